// File: rtl/tcdm_lic_rr.sv
// Word-interleaved logarithmic interconnect, N_MASTER cores to N_SLAVE banks, round-robin per bank.
// Request path is combinational; responses return MEM_LATENCY cycles after the bank handshake.
module tcdm_lic_rr #(
  parameter int unsigned N_MASTER       = 16,
  parameter int unsigned N_SLAVE        = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH/8,
  parameter int unsigned ADDR_MEM_WIDTH = 12,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter bit          WRITE_RESP     = 1'b1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [N_MASTER-1:0]                      data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_MASTER-1:0]                      data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]        data_be_i,
  output logic [N_MASTER-1:0]                      data_gnt_o,
  output logic [N_MASTER-1:0]                      data_r_valid_o,
  output logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [N_SLAVE-1:0]                       data_req_o,
  output logic [N_SLAVE-1:0][ADDR_MEM_WIDTH-1:0]   data_add_o,
  output logic [N_SLAVE-1:0]                       data_wen_o,
  output logic [N_SLAVE-1:0][DATA_WIDTH-1:0]       data_wdata_o,
  output logic [N_SLAVE-1:0][BE_WIDTH-1:0]         data_be_o,
  input  logic [N_SLAVE-1:0]                       data_gnt_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]       data_r_rdata_i
);

  localparam int unsigned OFF = $clog2(BE_WIDTH);
  localparam int unsigned SW  = $clog2(N_SLAVE);
  localparam int unsigned MW  = $clog2(N_MASTER);

  typedef struct packed {
    logic          vld;
    logic [MW-1:0] idx;
  } tag_t;

  logic [N_MASTER-1:0][SW-1:0]      bank_sel;
  logic [N_SLAVE-1:0][N_MASTER-1:0] req_mat;
  logic [N_SLAVE-1:0][MW-1:0]       rr_ptr;
  logic [N_SLAVE-1:0][MW-1:0]       win_idx;
  logic [N_SLAVE-1:0]               win_vld;
  logic [N_SLAVE-1:0]               hs;
  tag_t [N_SLAVE-1:0][MEM_LATENCY-1:0] tag_q;

  // Bits outside the bank/word fields are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^data_add_i;

  // Master index arithmetic modulo N_MASTER (N_MASTER need not be a power of two).
  function automatic logic [MW-1:0] wrap_add(input logic [MW-1:0] base, input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= N_MASTER) sum = sum - N_MASTER;
    return sum[MW-1:0];
  endfunction

  always_comb begin
    bank_sel = '0;
    req_mat  = '0;
    for (int unsigned m = 0; m < N_MASTER; m++) begin
      bank_sel[m] = data_add_i[m][OFF +: SW];
    end
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      for (int unsigned m = 0; m < N_MASTER; m++) begin
        req_mat[s][m] = data_req_i[m] && (bank_sel[m] == SW'(s));
      end
    end
  end

  // First requester at or above the pointer wins, scanning with wrap-around.
  always_comb begin
    win_vld = '0;
    win_idx = '0;
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        if (!win_vld[s] && req_mat[s][wrap_add(rr_ptr[s], i)]) begin
          win_vld[s] = 1'b1;
          win_idx[s] = wrap_add(rr_ptr[s], i);
        end
      end
    end
  end

  assign hs = win_vld & data_gnt_i;

  always_comb begin
    data_req_o   = '0;
    data_add_o   = '0;
    data_wen_o   = '0;
    data_wdata_o = '0;
    data_be_o    = '0;
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      data_req_o[s]   = win_vld[s];
      data_add_o[s]   = data_add_i[win_idx[s]][OFF+SW +: ADDR_MEM_WIDTH];
      data_wen_o[s]   = data_wen_i[win_idx[s]];
      data_wdata_o[s] = data_wdata_i[win_idx[s]];
      data_be_o[s]    = data_be_i[win_idx[s]];
    end
  end

  // A master targets exactly one bank, so at most one bank can set its grant bit.
  always_comb begin
    data_gnt_o = '0;
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      if (hs[s]) data_gnt_o[win_idx[s]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else begin
      for (int unsigned s = 0; s < N_SLAVE; s++) begin
        if (hs[s]) rr_ptr[s] <= wrap_add(win_idx[s], 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else begin
      for (int unsigned s = 0; s < N_SLAVE; s++) begin
        tag_q[s][0].vld <= hs[s] && (data_wen_i[win_idx[s]] || WRITE_RESP);
        tag_q[s][0].idx <= win_idx[s];
        for (int unsigned l = 1; l < MEM_LATENCY; l++) begin
          tag_q[s][l] <= tag_q[s][l-1];
        end
      end
    end
  end

  // Fixed latency plus single grant per cycle keeps responses collision-free per master.
  always_comb begin
    data_r_valid_o = '0;
    data_r_rdata_o = '0;
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      if (tag_q[s][MEM_LATENCY-1].vld) begin
        data_r_valid_o[tag_q[s][MEM_LATENCY-1].idx] = 1'b1;
        data_r_rdata_o[tag_q[s][MEM_LATENCY-1].idx] = data_r_rdata_i[s];
      end
    end
  end

endmodule

// File: tb/tb_tcdm_lic_rr.sv
// Directed bench for tcdm_lic_rr: three instances sharing stimulus (latency 1, 2, and 3 without write responses).
module tb_tcdm_lic_rr;
  localparam int NM = 16, NS = 32, AW = 32, DW = 32, BW = 4, MAW = 12;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [NM-1:0]          data_req_i, data_wen_i;
  logic [NM-1:0][AW-1:0]  data_add_i;
  logic [NM-1:0][DW-1:0]  data_wdata_i;
  logic [NM-1:0][BW-1:0]  data_be_i;
  logic [NS-1:0]          data_gnt_i;
  logic [NS-1:0][DW-1:0]  data_r_rdata_i;

  logic [NM-1:0] a_gnt, a_rv, b_gnt, b_rv, c_gnt, c_rv;
  logic [NM-1:0][DW-1:0] a_rdata, b_rdata, c_rdata;
  logic [NS-1:0] a_req_o, a_wen_o, b_req_o, b_wen_o, c_req_o, c_wen_o;
  logic [NS-1:0][MAW-1:0] a_add_o, b_add_o, c_add_o;
  logic [NS-1:0][DW-1:0] a_wdata_o, b_wdata_o, c_wdata_o;
  logic [NS-1:0][BW-1:0] a_be_o, b_be_o, c_be_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  tcdm_lic_rr #(.MEM_LATENCY(1), .WRITE_RESP(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_gnt_o(a_gnt), .data_r_valid_o(a_rv), .data_r_rdata_o(a_rdata),
    .data_req_o(a_req_o), .data_add_o(a_add_o), .data_wen_o(a_wen_o),
    .data_wdata_o(a_wdata_o), .data_be_o(a_be_o), .data_gnt_i(data_gnt_i),
    .data_r_rdata_i(data_r_rdata_i));

  tcdm_lic_rr #(.MEM_LATENCY(2), .WRITE_RESP(1'b1)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_gnt_o(b_gnt), .data_r_valid_o(b_rv), .data_r_rdata_o(b_rdata),
    .data_req_o(b_req_o), .data_add_o(b_add_o), .data_wen_o(b_wen_o),
    .data_wdata_o(b_wdata_o), .data_be_o(b_be_o), .data_gnt_i(data_gnt_i),
    .data_r_rdata_i(data_r_rdata_i));

  tcdm_lic_rr #(.MEM_LATENCY(3), .WRITE_RESP(1'b0)) u_dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_gnt_o(c_gnt), .data_r_valid_o(c_rv), .data_r_rdata_o(c_rdata),
    .data_req_o(c_req_o), .data_add_o(c_add_o), .data_wen_o(c_wen_o),
    .data_wdata_o(c_wdata_o), .data_be_o(c_be_o), .data_gnt_i(data_gnt_i),
    .data_r_rdata_i(data_r_rdata_i));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int s);
    return 32'hA500_0000 | 32'(s);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    data_req_i   = '0;
    data_add_i   = '0;
    data_wen_i   = '1;
    data_wdata_i = '0;
    data_be_i    = '0;
    data_gnt_i   = '1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) data_r_rdata_i[s] = pat(s);

    // Reset state
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    check("rst_rv_a", a_rv, 0);
    check("rst_rv_b", b_rv, 0);
    check("rst_rv_c", c_rv, 0);
    check("rst_gnt", a_gnt, 0);
    check("rst_req_o", a_req_o, 0);
    check("rst_rdata_zero", a_rdata[0], 0);

    // Single load: 0x104 -> bank 1, word 2
    do_reset();
    data_r_rdata_i[1] = 32'hDEAD_BEEF;
    data_req_i[0] = 1'b1;
    data_add_i[0] = 32'h0000_0104;
    #1;
    check("single_req_o", a_req_o, 32'h0000_0002);
    check("single_add_o", a_add_o[1], 2);
    check("single_wen_o", a_wen_o[1], 1);
    check("single_gnt", a_gnt, 16'h0001);
    check("single_rv_early", a_rv, 0);
    tick();
    data_req_i[0] = 1'b0;
    #1;
    check("single_rv", a_rv, 16'h0001);
    check("single_rdata", a_rdata[0], 32'hDEAD_BEEF);
    check("single_rdata_idle", a_rdata[1], 0);
    tick();
    #1;
    check("single_rv_done", a_rv, 0);
    data_r_rdata_i[1] = pat(1);

    // Round-robin M0..M3 on bank 5
    do_reset();
    for (int m = 0; m < 4; m++) begin
      data_req_i[m] = 1'b1;
      data_add_i[m] = 32'h14;
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_gnt", a_gnt, 64'd1 << (c % 4));
      if (c > 0) begin
        check("rr_rv", a_rv, 64'd1 << (c - 1));
        check("rr_rdata", a_rdata[c-1], pat(5));
      end
      tick();
    end
    clear_inputs();

    // Stalled bank 3 with M2 and M7 requesting
    do_reset();
    data_req_i[2] = 1'b1; data_add_i[2] = 32'h0C; data_wdata_i[2] = 32'h2222;
    data_req_i[7] = 1'b1; data_add_i[7] = 32'h0C; data_wdata_i[7] = 32'h7777;
    data_gnt_i[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_gnt", a_gnt, 0);
      check("stall_req", a_req_o[3], 1);
      check("stall_win", a_wdata_o[3], 32'h2222);
      tick();
    end
    data_gnt_i[3] = 1'b1;
    #1;
    check("unstall_gnt", a_gnt, 16'h0004);
    tick();
    #1;
    check("rr_after_stall_gnt", a_gnt, 16'h0080);
    check("rr_after_stall_win", a_wdata_o[3], 32'h7777);
    check("stall_resp", a_rv, 16'h0004);
    tick();
    data_gnt_i[3] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("hold_gnt", a_gnt, 0);
      check("hold_win", a_wdata_o[3], 32'h2222);
      tick();
    end
    clear_inputs();

    // Store then load from M1 to bank 0; write responses on a/b only
    do_reset();
    data_req_i[1] = 1'b1; data_add_i[1] = 32'h0; data_wen_i[1] = 1'b0; data_wdata_i[1] = 32'h1111;
    #1;
    check("st_gnt", c_gnt, 16'h0002);
    check("st_wen_o", c_wen_o[0], 0);
    check("st_wdata_o", c_wdata_o[0], 32'h1111);
    tick();
    data_wen_i[1] = 1'b1;
    #1;
    check("ld_gnt", c_gnt, 16'h0002);
    check("st_wresp_a", a_rv, 16'h0002);
    check("st_none_c1", c_rv, 0);
    tick();
    data_req_i[1] = 1'b0;
    for (int c = 2; c < 6; c++) begin
      #1;
      check("lat3_rv", c_rv, (c == 4) ? 64'h2 : 64'h0);
      if (c == 4) check("lat3_rdata", c_rdata[1], pat(0));
      if (c == 2 || c == 3) check("lat2_rv", b_rv, 16'h0002);
      tick();
    end

    // 16 masters to 16 distinct banks (bank 2m, word m)
    do_reset();
    for (int m = 0; m < NM; m++) begin
      data_req_i[m] = 1'b1;
      data_add_i[m] = (32'(2 * m) << 2) | (32'(m) << 7);
      data_be_i[m]  = 4'(m);
    end
    #1;
    check("par_gnt", a_gnt, 16'hFFFF);
    check("par_req_o", a_req_o, 32'h5555_5555);
    check("par_add6", a_add_o[6], 3);
    check("par_add30", a_add_o[30], 15);
    check("par_be10", a_be_o[10], 5);
    tick();
    clear_inputs();
    #1;
    check("par_rv", a_rv, 16'hFFFF);
    for (int m = 0; m < NM; m++) check("par_rdata", a_rdata[m], pat(2 * m));

    // Reset with a response in flight on the latency-2 instance
    do_reset();
    data_req_i[0] = 1'b1; data_add_i[0] = 32'h24;
    data_req_i[4] = 1'b1; data_add_i[4] = 32'h24;
    #1;
    check("pre_rst_gnt", b_gnt, 16'h0001);
    tick();
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    check("inflight_rst_rv", b_rv, 0);
    tick();
    #1;
    check("inflight_rst_rv2", b_rv, 0);
    rst_ni = 1'b1;
    tick();
    #1;
    check("inflight_post_rv", b_rv, 0);
    data_req_i[0] = 1'b1; data_add_i[0] = 32'h24;
    data_req_i[4] = 1'b1; data_add_i[4] = 32'h24;
    #1;
    check("post_rst_gnt", b_gnt, 16'h0001);
    tick();
    clear_inputs();
    #1;
    check("post_rst_rv_b_early", b_rv, 0);
    tick();
    #1;
    check("post_rst_rv_b", b_rv, 16'h0001);
    check("post_rst_rdata_b", b_rdata[0], pat(9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
